// File: rtl/video_pattern_gen_if.sv
// Video pattern generator signal bundle: mode/colour controls in, sync/DE/RGB timing out.
// The master modport is the generator side; the slave modport is the consumer/driver side.
interface video_pattern_gen_if;
  logic [1:0]  i_mode;
  logic [23:0] i_solid_rgb;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_de;
  logic [23:0] o_rgb;
  logic        o_frame_start;

  modport master (
    input  i_mode, i_solid_rgb,
    output o_hsync, o_vsync, o_de, o_rgb, o_frame_start
  );

  modport slave (
    output i_mode, i_solid_rgb,
    input  o_hsync, o_vsync, o_de, o_rgb, o_frame_start
  );
endinterface

// File: rtl/video_pattern_gen.sv
// Video timing + test pattern generator (bars, ramp, grid, solid), all outputs registered.
// Optional macro VIDEO_PATTERN_SCROLL_EN: bars scroll left one pixel per frame.
module video_pattern_gen #(
  parameter int H_ACTIVE      = 1280,
  parameter int H_FP          = 110,
  parameter int H_SYNC        = 40,
  parameter int H_BP          = 220,
  parameter int V_ACTIVE      = 720,
  parameter int V_FP          = 5,
  parameter int V_SYNC        = 5,
  parameter int V_BP          = 20,
  parameter bit HS_POL        = 1'b1,
  parameter bit VS_POL        = 1'b1,
  parameter int NUM_BARS      = 8,
  parameter int ROTATE_FRAMES = 120
) (
  input logic                 i_pixclk,
  input logic                 i_reset,
  video_pattern_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int BW      = H_ACTIVE / NUM_BARS;
  localparam int CW      = $clog2(BW + 1);
  localparam int FW      = $clog2(ROTATE_FRAMES + 1);

  typedef struct packed {
    logic [2:0]    bar;
    logic [CW-1:0] cnt;
  } bar_pos_t;

  function automatic logic [23:0] palette(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'h00FFFF;
      3'd2:    c = 24'hFFFF00;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'h0000FF;
      3'd6:    c = 24'hFF0000;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Advance one pixel; the last bar saturates and absorbs the remainder.
  function automatic bar_pos_t bar_step(input bar_pos_t p);
    bar_pos_t n;
    n = p;
    if (p.bar != 3'(NUM_BARS - 1)) begin
      if (p.cnt == CW'(BW - 1)) begin
        n.bar = p.bar + 3'd1;
        n.cnt = '0;
      end else begin
        n.cnt = p.cnt + CW'(1);
      end
    end
    return n;
  endfunction

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [2:0]    rot_q, rot_d;
  bar_pos_t      pos_q, pos_d;
  logic [1:0]    mode_q, mode_d;
  logic [23:0]   solid_q, solid_d;

  logic          hsync_q, vsync_q, de_q, fs_q;
  logic          hsync_d, vsync_d, de_d, fs_d;
  logic [23:0]   rgb_q, rgb_d;

  logic          line_end, frame_end, first_px;
  logic [1:0]    mode_eff;
  logic [23:0]   solid_eff;
  logic [7:0]    h_lo;
  logic [3:0]    v_lo;

`ifdef VIDEO_PATTERN_SCROLL_EN
  localparam int XW = $clog2(H_ACTIVE + 1);
  logic [XW-1:0] off_q, off_d, col_q, col_d;
  bar_pos_t      off_pos_q, off_pos_d;
`endif

  assign line_end  = (h_q == HW'(H_TOTAL - 1));
  assign frame_end = line_end && (v_q == VW'(V_TOTAL - 1));
  assign first_px  = (h_q == '0) && (v_q == '0);
  // Controls presented at the first pixel apply to that whole frame.
  assign mode_eff  = first_px ? vid.i_mode      : mode_q;
  assign solid_eff = first_px ? vid.i_solid_rgb : solid_q;
  assign h_lo      = 8'(h_q);
  assign v_lo      = 4'(v_q);

  always_comb begin
    h_d     = line_end ? '0 : h_q + HW'(1);
    v_d     = v_q;
    fcnt_d  = fcnt_q;
    rot_d   = rot_q;
    mode_d  = mode_eff;
    solid_d = solid_eff;
    pos_d   = pos_q;
    if (line_end) v_d = frame_end ? '0 : v_q + VW'(1);
    if (frame_end) begin
      if (fcnt_q == FW'(ROTATE_FRAMES - 1)) begin
        fcnt_d = '0;
        rot_d  = rot_q + 3'd1;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
`ifdef VIDEO_PATTERN_SCROLL_EN
    off_d     = off_q;
    off_pos_d = off_pos_q;
    col_d     = col_q;
    if (frame_end) begin
      if (off_q == XW'(H_ACTIVE - 1)) begin
        off_d     = '0;
        off_pos_d = '0;
      end else begin
        off_d     = off_q + XW'(1);
        off_pos_d = bar_step(off_pos_q);
      end
    end
    // Each line starts at the scrolled column and wraps back to bar 0 at the right edge.
    if (line_end) begin
      col_d = off_d;
      pos_d = off_pos_d;
    end else if (h_q < HW'(H_ACTIVE)) begin
      if (col_q == XW'(H_ACTIVE - 1)) begin
        col_d = '0;
        pos_d = '0;
      end else begin
        col_d = col_q + XW'(1);
        pos_d = bar_step(pos_q);
      end
    end
`else
    if (line_end) begin
      pos_d = '0;
    end else if (h_q < HW'(H_ACTIVE)) begin
      pos_d = bar_step(pos_q);
    end
`endif
  end

  always_comb begin
    hsync_d = ((h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC)))
              ? HS_POL : ~HS_POL;
    vsync_d = ((v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC)))
              ? VS_POL : ~VS_POL;
    de_d    = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
    fs_d    = first_px;
    rgb_d   = '0;
    if (de_d) begin
      case (mode_eff)
        2'd0:    rgb_d = palette(pos_q.bar + rot_q);
        2'd1:    rgb_d = {h_lo, h_lo, h_lo};
        2'd2:    rgb_d = ((h_lo[3:0] == 4'd0) || (v_lo == 4'd0)) ? 24'hFFFFFF : 24'h000000;
        default: rgb_d = solid_eff;
      endcase
    end
  end

  always_ff @(posedge i_pixclk or posedge i_reset) begin
    if (i_reset) begin
      h_q       <= '0;
      v_q       <= '0;
      fcnt_q    <= '0;
      rot_q     <= '0;
      pos_q     <= '0;
      mode_q    <= '0;
      solid_q   <= '0;
      hsync_q   <= ~HS_POL;
      vsync_q   <= ~VS_POL;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
      rgb_q     <= '0;
`ifdef VIDEO_PATTERN_SCROLL_EN
      off_q     <= '0;
      off_pos_q <= '0;
      col_q     <= '0;
`endif
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      fcnt_q    <= fcnt_d;
      rot_q     <= rot_d;
      pos_q     <= pos_d;
      mode_q    <= mode_d;
      solid_q   <= solid_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      fs_q      <= fs_d;
      rgb_q     <= rgb_d;
`ifdef VIDEO_PATTERN_SCROLL_EN
      off_q     <= off_d;
      off_pos_q <= off_pos_d;
      col_q     <= col_d;
`endif
    end
  end

  assign vid.o_hsync       = hsync_q;
  assign vid.o_vsync       = vsync_q;
  assign vid.o_de          = de_q;
  assign vid.o_rgb         = rgb_q;
  assign vid.o_frame_start = fs_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen with the small timing set; checks against a frame-arithmetic model.
module tb_video_pattern_gen;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;
  localparam int NB = 4, RF = 2;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [23:0] rgb;
  } vout_t;

  typedef struct packed {
    logic [1:0]  mode;
    logic [23:0] solid;
    logic [7:0]  frame;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [23:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n_out = 0;
  logic [1:0]  cur_mode = 2'd0;
  logic [23:0] cur_solid = 24'd0;
  logic [1:0]  fm = 2'd0;
  logic [23:0] fsol = 24'd0;
  vec_t vecs[$];

  video_pattern_gen_if vif ();

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .NUM_BARS(NB), .ROTATE_FRAMES(RF)
  ) dut (
    .i_pixclk(clk),
    .i_reset (rst),
    .vid     (vif)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pal(input int i);
    case (i % 8)
      0: return 24'hFFFFFF;
      1: return 24'h00FFFF;
      2: return 24'hFFFF00;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'h0000FF;
      6: return 24'hFF0000;
      default: return 24'h000000;
    endcase
  endfunction

  // Expected output for the n-th output cycle after reset release.
  function automatic vout_t model(input int n, input logic [1:0] m, input logic [23:0] s);
    vout_t e;
    int h, v, f, col, bar;
    h = n % HT;
    v = (n / HT) % VT;
    f = n / FT;
    e.hs  = (h >= HA + HFP) && (h < HA + HFP + HSY);
    e.vs  = (v >= VA + VFP) && (v < VA + VFP + VSY);
    e.de  = (h < HA) && (v < VA);
    e.fs  = (h == 0) && (v == 0);
    e.rgb = 24'h0;
    if (e.de) begin
      case (m)
        2'd0: begin
`ifdef VIDEO_PATTERN_SCROLL_EN
          col = (h + (f % HA)) % HA;
`else
          col = h;
`endif
          bar = col / (HA / NB);
          if (bar > NB - 1) bar = NB - 1;
          e.rgb = pal(bar + (f / RF) % 8);
        end
        2'd1: e.rgb = {3{8'(h)}};
        2'd2: e.rgb = ((h % 16 == 0) || (v % 16 == 0)) ? 24'hFFFFFF : 24'h0;
        default: e.rgb = s;
      endcase
    end
    return e;
  endfunction

  task automatic check_vec(input string name, input vout_t exp);
    vout_t act;
    act = {vif.o_hsync, vif.o_vsync, vif.o_de, vif.o_frame_start, vif.o_rgb};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got hs%b vs%b de%b fs%b rgb=%h want hs%b vs%b de%b fs%b rgb=%h",
               name, n_out, act.hs, act.vs, act.de, act.fs, act.rgb,
               exp.hs, exp.vs, exp.de, exp.fs, exp.rgb);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [23:0] s);
    cur_mode  = m;
    cur_solid = s;
    vif.i_mode      = m;
    vif.i_solid_rgb = s;
  endtask

  // Reset takes effect immediately, then releases between clock edges.
  task automatic do_reset(input logic [1:0] m, input logic [23:0] s);
    rst = 1'b1;
    #1;
    check_vec("reset_async", '0);
    drive(m, s);
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_hold", '0);
    @(negedge clk);
    rst   = 1'b0;
    n_out = 0;
  endtask

  task automatic run_stream(input int ncyc, input bit rnd);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      if ((n_out % HT == 0) && ((n_out / HT) % VT == 0)) begin
        fm   = cur_mode;
        fsol = cur_solid;
      end
      check_vec("stream", model(n_out, fm, fsol));
      n_out++;
      if (rnd && ($urandom_range(0, 59) == 0))
        drive(2'($urandom_range(0, 3)), 24'($urandom));
    end
  endtask

  initial begin
    vif.i_mode      = 2'd0;
    vif.i_solid_rgb = 24'd0;

    vecs.push_back('{2'd0, 24'h0, 8'd0, 8'd0, 8'd0, 24'hFFFFFF});
    vecs.push_back('{2'd0, 24'h0, 8'd0, 8'd4, 8'd0, 24'h00FFFF});
    vecs.push_back('{2'd0, 24'h0, 8'd0, 8'd8, 8'd0, 24'hFFFF00});
    vecs.push_back('{2'd0, 24'h0, 8'd0, 8'd12, 8'd0, 24'h00FF00});
    vecs.push_back('{2'd0, 24'h0, 8'd0, 8'd15, 8'd3, 24'h00FF00});
    vecs.push_back('{2'd0, 24'h0, 8'd2, 8'd0, 8'd0, 24'h00FFFF});
    vecs.push_back('{2'd0, 24'h0, 8'd16, 8'd0, 8'd0, 24'hFFFFFF});
    vecs.push_back('{2'd0, 24'h0, 8'd16, 8'd5, 8'd0, 24'h00FFFF});
`ifdef VIDEO_PATTERN_SCROLL_EN
    vecs.push_back('{2'd0, 24'h0, 8'd1, 8'd3, 8'd0, 24'h00FFFF});
    vecs.push_back('{2'd0, 24'h0, 8'd1, 8'd15, 8'd0, 24'hFFFFFF});
`else
    vecs.push_back('{2'd0, 24'h0, 8'd1, 8'd3, 8'd0, 24'hFFFFFF});
    vecs.push_back('{2'd0, 24'h0, 8'd1, 8'd15, 8'd0, 24'h00FF00});
`endif
    vecs.push_back('{2'd2, 24'h0, 8'd0, 8'd0, 8'd2, 24'hFFFFFF});
    vecs.push_back('{2'd2, 24'h0, 8'd0, 8'd7, 8'd0, 24'hFFFFFF});
    vecs.push_back('{2'd2, 24'h0, 8'd0, 8'd1, 8'd1, 24'h000000});
    vecs.push_back('{2'd1, 24'h0, 8'd0, 8'd9, 8'd1, 24'h090909});
    vecs.push_back('{2'd3, 24'h123456, 8'd0, 8'd3, 8'd2, 24'h123456});

    foreach (vecs[k]) begin
      int tgt;
      do_reset(vecs[k].mode, vecs[k].solid);
      tgt = int'(vecs[k].frame) * FT + int'(vecs[k].y) * HT + int'(vecs[k].x);
      run_stream(tgt + 1, 1'b0);
      checks++;
      if (vif.o_rgb !== vecs[k].exp) begin
        errors++;
        $display("FAIL vec%0d pixel f%0d (%0d,%0d) got %h want %h",
                 k, vecs[k].frame, vecs[k].x, vecs[k].y, vif.o_rgb, vecs[k].exp);
      end
    end

    // Mode switch mid-frame: bars finish the frame, solid starts on the next one.
    do_reset(2'd0, 24'h0);
    run_stream(HT + 5 + 1, 1'b0);
    drive(2'd3, 24'h123456);
    run_stream(FT - (HT + 6), 1'b0);
    run_stream(1, 1'b0);
    checks++;
    if (vif.o_rgb !== 24'h123456) begin
      errors++;
      $display("FAIL mode_switch next frame got %h want 123456", vif.o_rgb);
    end
    run_stream(FT - 1, 1'b0);

    // Reset in the middle of line 2, then frame_start on the first output cycle.
    do_reset(2'd1, 24'h0);
    run_stream(2 * HT + 10 + 1, 1'b0);
    do_reset(2'd0, 24'h0);
    run_stream(1, 1'b0);
    checks++;
    if (vif.o_frame_start !== 1'b1) begin
      errors++;
      $display("FAIL post_reset frame_start got %b want 1", vif.o_frame_start);
    end

    // Randomized controls over many frames against the model.
    do_reset(2'($urandom_range(0, 3)), 24'($urandom));
    run_stream(20 * FT, 1'b1);
    do_reset(2'd0, 24'h0);
    run_stream(17 * FT, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
